// File: rtl/brecv_fsm.sv
// brecv_fsm: receive side of a toggle req/ack word transfer from the A clock domain into bclk
module brecv_fsm #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             bclk,
  input  logic             brst,
  input  logic             areq,
  input  logic [WIDTH-1:0] adata,
  output logic [WIDTH-1:0] bdata,
  output logic             bvalid,
  input  logic             bready,
  output logic             back,
  output logic [CNT_W-1:0] bcount,
  output logic             boverrun,
  input  logic             bclr
);
  typedef enum logic {IDLE, VALID} state_t;
  state_t r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [WIDTH-1:0] r_bdata, w_bdata_nxt;
  logic [CNT_W-1:0] r_bcount, w_bcount_nxt;
  logic r_bvalid, w_bvalid_nxt, r_back, w_back_nxt, r_ovr, w_ovr_nxt;
  logic w_req_s, w_pend, w_acc;
  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign w_pend  = w_req_s != r_back;
  assign w_acc   = r_state == VALID && bready;
  always_comb begin
    w_state_nxt  = r_state;
    w_bdata_nxt  = r_bdata;
    w_bvalid_nxt = r_bvalid;
    w_back_nxt   = r_back;
    w_bcount_nxt = r_bcount;
    // a second toggle while holding a word brings req_s back level with back
    w_ovr_nxt    = (r_state == VALID && !w_pend) || (r_ovr && !bclr);
    if (r_state == IDLE && w_pend) begin
      w_state_nxt  = VALID;
      w_bdata_nxt  = adata;
      w_bvalid_nxt = 1'b1;
    end
    if (w_acc) begin
      w_state_nxt  = IDLE;
      w_bvalid_nxt = 1'b0;
      w_back_nxt   = ~r_back;
      w_bcount_nxt = r_bcount + CNT_W'(1);
    end
  end
  always_ff @(posedge bclk) begin
    if (brst) begin
      r_state  <= IDLE;
      r_sync   <= '0;
      r_bdata  <= '0;
      r_bvalid <= 1'b0;
      r_back   <= 1'b0;
      r_bcount <= '0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sync   <= {r_sync[SYNC_STAGES-2:0], areq};
      r_bdata  <= w_bdata_nxt;
      r_bvalid <= w_bvalid_nxt;
      r_back   <= w_back_nxt;
      r_bcount <= w_bcount_nxt;
      r_ovr    <= w_ovr_nxt;
    end
  end
  assign bdata    = r_bdata;
  assign bvalid   = r_bvalid;
  assign back     = r_back;
  assign bcount   = r_bcount;
  assign boverrun = r_ovr;
endmodule

// File: tb/tb_brecv_fsm.sv
// tb_brecv_fsm: directed and streaming checks of brecv_fsm with a data-order scoreboard
module tb_brecv_fsm;
  logic bclk = 1'b0, brst, areq, bready, bclr, bvalid, back, boverrun;
  logic [7:0] adata, bdata, bcount;
  logic [7:0] sb[$];
  int n = 0, err = 0;
  brecv_fsm #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .bclk(bclk), .brst(brst), .areq(areq), .adata(adata), .bdata(bdata),
    .bvalid(bvalid), .bready(bready), .back(back), .bcount(bcount),
    .boverrun(boverrun), .bclr(bclr)
  );
  always #5 bclk = ~bclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    if (!brst && bvalid && bready) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else chk("data", bdata, sb.pop_front());
    end
    @(posedge bclk);
    #1;
  endtask
  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask
  initial begin
    brst = 1; areq = 1; bready = 0; bclr = 0; adata = 8'h00;
    ticks(3);
    chk("rst_valid", bvalid, 0);
    chk("rst_data", bdata, 0);
    chk("rst_back", back, 0);
    chk("rst_cnt", bcount, 0);
    chk("rst_ovr", boverrun, 0);
    brst = 0; areq = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_valid", bvalid, 0);
    end
    // single transfer
    bready = 1; areq = 1; adata = 8'hA5; sb.push_back(8'hA5);
    ticks(2);
    chk("e2_valid", bvalid, 0);
    tick();
    chk("e3_valid", bvalid, 1);
    chk("e3_data", bdata, 8'hA5);
    tick();
    chk("e4_valid", bvalid, 0);
    chk("e4_back", back, 1);
    chk("e4_cnt", bcount, 1);
    // backpressure
    bready = 0; areq = 0; adata = 8'h3C; sb.push_back(8'h3C);
    ticks(3);
    chk("bp_valid", bvalid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_v", bvalid, 1);
      chk("bp_hold_d", bdata, 8'h3C);
      chk("bp_hold_b", back, 1);
    end
    bready = 1;
    tick();
    chk("bp_back", back, 0);
    chk("bp_valid0", bvalid, 0);
    chk("bp_cnt", bcount, 2);
    // overrun
    bready = 0; areq = 1; adata = 8'h5A; sb.push_back(8'h5A);
    ticks(3);
    chk("ov_valid", bvalid, 1);
    areq = 0;
    ticks(2);
    chk("ov_pre", boverrun, 0);
    tick();
    chk("ov_set", boverrun, 1);
    bclr = 1;
    tick();
    bclr = 0;
    chk("ov_clr_vs_set", boverrun, 1);
    sb.push_back(8'h5A);
    bready = 1;
    tick();
    chk("ov_acc_back", back, 1);
    chk("ov_acc_cnt", bcount, 3);
    bready = 0;
    tick();
    chk("ov_recap", bvalid, 1);
    bclr = 1;
    tick();
    bclr = 0;
    chk("ov_clr", boverrun, 0);
    bready = 1;
    tick();
    chk("ov_drain", back, 0);
    chk("ov_cnt", bcount, 4);
    bready = 0;
    // stream with wrap
    brst = 1;
    ticks(2);
    brst = 0;
    sb.delete();
    chk("st_cnt0", bcount, 0);
    for (int t = 0; t < 257; t++) begin
      adata = 8'($urandom);
      areq = ~areq;
      sb.push_back(adata);
      for (int w = 0; w < 200 && back !== areq; w++) begin
        bready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("st_ack", back, areq);
    end
    bready = 0;
    chk("st_cnt_wrap", bcount, 1);
    chk("st_ovr", boverrun, 0);
    chk("st_sb_left", sb.size(), 0);
    // mid-transfer reset
    areq = ~areq; adata = 8'hC3; sb.push_back(8'hC3);
    ticks(3);
    chk("mr_valid", bvalid, 1);
    brst = 1; areq = 0;
    tick();
    chk("mr_valid0", bvalid, 0);
    chk("mr_back", back, 0);
    chk("mr_cnt", bcount, 0);
    sb.delete();
    brst = 0;
    ticks(5);
    chk("mr_idle", bvalid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
